// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: request/response bundle between the fetch-stage PC controller and its pipeline.
interface pc_ctrl_if #(parameter int WIDTH = 32);
    logic stall, exc, jump, branch_taken, halt, resume, call, ret;
    logic [WIDTH-1:0] jump_target, branch_target, pc, pc_seq;
    logic pc_valid, misalign, ras_underflow;
    modport master (
        output stall, exc, jump, jump_target, branch_taken, branch_target, halt, resume, call, ret,
        input pc, pc_seq, pc_valid, misalign, ras_underflow
    );
    modport slave (
        input stall, exc, jump, jump_target, branch_taken, branch_target, halt, resume, call, ret,
        output pc, pc_seq, pc_valid, misalign, ras_underflow
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage program counter with boot cycle, stall hold, prioritised redirects and halt FSM.
// Defining PC_RAS_EN adds a RAS_DEPTH-entry circular return-address stack driven by call/ret.
module pc_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEP = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 'h80,
    parameter int ALIGN_BITS = 2,
    parameter int RAS_DEPTH = 4
) (
    input logic clock,
    input logic reset,
    pc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam logic [WIDTH-1:0] AMASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);
    state_t state, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, tgt, ras_top, pc_inc;
    logic valid_q, mis_q, mis_d, unf_d, take, push, pop;
    logic ret_en, call_en, ras_empty;
    assign pc_inc = pc_q + WIDTH'(STEP);
    always_ff @(posedge clock) begin
        if (reset) state <= BOOT;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            BOOT: state_d = RUN;
            RUN: state_d = (!bus.exc && !bus.stall && bus.halt) ? HALT : RUN;
            HALT: state_d = (bus.exc || bus.resume) ? RUN : HALT;
            default: state_d = BOOT;
        endcase
    end
    // Redirect selection: exc, then stall/halt hold, then ret, jump, branch, sequential.
    always_comb begin
        pc_d = pc_q;
        mis_d = 1'b0;
        unf_d = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        take = 1'b0;
        tgt = bus.branch_target;
        if (state != BOOT && bus.exc) pc_d = EXC_VECTOR;
        else if (state == RUN && !bus.stall && !bus.halt) begin
            if (ret_en && ras_empty) begin
                pc_d = EXC_VECTOR;
                unf_d = 1'b1;
            end else begin
                take = ret_en || bus.jump || bus.branch_taken;
                tgt = ret_en ? ras_top : bus.jump ? bus.jump_target : bus.branch_target;
                pop = ret_en;
                push = call_en && bus.jump && !ret_en;
                mis_d = take && |(tgt & AMASK);
                pc_d = mis_d ? EXC_VECTOR : take ? tgt : pc_inc;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
            valid_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            valid_q <= state_d == RUN;
            mis_q <= mis_d;
        end
    end
    assign bus.pc = pc_q;
    assign bus.pc_seq = pc_inc;
    assign bus.pc_valid = valid_q;
    assign bus.misalign = mis_q;
`ifdef PC_RAS_EN
    localparam int PW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] top, top_inc, top_dec;
    logic [CW-1:0] cnt;
    logic unf_q;
    assign ret_en = bus.ret;
    assign call_en = bus.call;
    assign ras_empty = cnt == '0;
    assign ras_top = ras[top];
    assign top_inc = top == PW'(RAS_DEPTH - 1) ? '0 : top + PW'(1);
    assign top_dec = top == '0 ? PW'(RAS_DEPTH - 1) : top - PW'(1);
    // When full, top_inc lands on the oldest entry, so a push overwrites it.
    always_ff @(posedge clock) begin
        if (reset) begin
            top <= '0;
            cnt <= '0;
            unf_q <= 1'b0;
        end else begin
            unf_q <= unf_d;
            if (push) begin
                ras[top_inc] <= pc_inc;
                top <= top_inc;
                cnt <= cnt == CW'(RAS_DEPTH) ? cnt : cnt + CW'(1);
            end else if (pop) begin
                top <= top_dec;
                cnt <= cnt - CW'(1);
            end
        end
    end
    assign bus.ras_underflow = unf_q;
`else
    localparam int unused_depth = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras = bus.call ^ bus.ret ^ push ^ pop ^ unf_d;
    assign ret_en = 1'b0;
    assign call_en = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_top = '0;
    assign bus.ras_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: scoreboard bench; a driver pushes model-predicted outputs, a monitor pops and compares.
module tb_pc_ctrl;
    typedef struct packed {
        logic rst, stall, exc, jump, br, halt, resume, call, ret;
        logic [31:0] jt, bt;
    } stim_t;
    typedef struct {
        logic [31:0] pc;
        logic v, mis, unf;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    int st;
    logic [31:0] mpc;
    logic mmis, munf;
    logic [31:0] stk[$];
    pc_ctrl_if #(.WIDTH(32)) bus();
    pc_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic load(input logic [31:0] t);
        if (t % 4 != 0) begin
            mpc = 32'h80;
            mmis = 1'b1;
        end else mpc = t;
    endtask
    // Behavioural model: st 0=boot, 1=run, 2=halt.
    task automatic model(input stim_t s);
        mmis = 1'b0;
        munf = 1'b0;
        if (s.rst) begin
            st = 0;
            mpc = 32'h0;
            stk.delete();
        end else if (st == 0) st = 1;
        else if (st == 2) begin
            if (s.exc) begin
                st = 1;
                mpc = 32'h80;
            end else if (s.resume) st = 1;
        end else if (s.exc) mpc = 32'h80;
        else if (s.stall) begin
        end else if (s.halt) st = 2;
`ifdef PC_RAS_EN
        else if (s.ret) begin
            if (stk.size() == 0) begin
                mpc = 32'h80;
                munf = 1'b1;
            end else load(stk.pop_back());
        end
`endif
        else if (s.jump) begin
`ifdef PC_RAS_EN
            if (s.call) begin
                stk.push_back(mpc + 32'd4);
                if (stk.size() > 4) void'(stk.pop_front());
            end
`endif
            load(s.jt);
        end else if (s.br) load(s.bt);
        else mpc = mpc + 32'd4;
    endtask
    task automatic cyc(input stim_t s);
        exp_t e;
        @(negedge clock);
        reset = s.rst;
        bus.stall = s.stall;
        bus.exc = s.exc;
        bus.jump = s.jump;
        bus.jump_target = s.jt;
        bus.branch_taken = s.br;
        bus.branch_target = s.bt;
        bus.halt = s.halt;
        bus.resume = s.resume;
        bus.call = s.call;
        bus.ret = s.ret;
        model(s);
        e.pc = mpc;
        e.v = st == 1;
        e.mis = mmis;
        e.unf = munf;
        exp_q.push_back(e);
    endtask
    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("pc_seq", bus.pc_seq, e.pc + 32'd4);
            chk("pc_valid", 32'(bus.pc_valid), 32'(e.v));
            chk("misalign", 32'(bus.misalign), 32'(e.mis));
            chk("ras_underflow", 32'(bus.ras_underflow), 32'(e.unf));
        end
    end
    initial begin
        stim_t s;
        {bus.stall, bus.exc, bus.jump, bus.branch_taken, bus.halt, bus.resume, bus.call, bus.ret} = '0;
        bus.jump_target = '0;
        bus.branch_target = '0;
        s = idle(); s.rst = 1'b1; cyc(s);
        repeat (5) cyc(idle());
        s = idle(); s.stall = 1'b1; s.halt = 1'b1; cyc(s); cyc(s);
        s = idle(); s.jump = 1'b1; s.jt = 32'h40; s.br = 1'b1; s.bt = 32'h200; cyc(s);
        s = idle(); s.br = 1'b1; s.bt = 32'h22; cyc(s);
        cyc(idle());
        s = idle(); s.exc = 1'b1; s.jump = 1'b1; s.jt = 32'h22; cyc(s);
        s = idle(); s.jump = 1'b1; s.jt = 32'h13; cyc(s);
        s = idle(); s.rst = 1'b1; cyc(s);
        repeat (3) cyc(idle());
        s = idle(); s.halt = 1'b1; cyc(s);
        cyc(idle());
        s = idle(); s.jump = 1'b1; s.jt = 32'h300; cyc(s);
        s = idle(); s.resume = 1'b1; cyc(s);
        cyc(idle());
        s = idle(); s.halt = 1'b1; s.exc = 1'b1; cyc(s);
        s = idle(); s.halt = 1'b1; cyc(s);
        s = idle(); s.exc = 1'b1; s.resume = 1'b1; cyc(s);
        s = idle(); s.jump = 1'b1; s.jt = 32'hFFFF_FFFC; cyc(s);
        cyc(idle());
        s = idle(); s.stall = 1'b1; cyc(s);
        s.rst = 1'b1; cyc(s);
        cyc(idle());
`ifdef PC_RAS_EN
        repeat (4) cyc(idle());
        s = idle(); s.jump = 1'b1; s.call = 1'b1; s.jt = 32'h100; cyc(s);
        s = idle(); s.ret = 1'b1; s.jump = 1'b1; s.call = 1'b1; s.jt = 32'h200; cyc(s);
        s = idle(); s.ret = 1'b1; cyc(s);
        cyc(idle());
`endif
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst = $urandom_range(0, 99) == 0;
            s.exc = $urandom_range(0, 15) == 0;
            s.stall = $urandom_range(0, 3) == 0;
            s.halt = $urandom_range(0, 9) == 0;
            s.resume = $urandom_range(0, 2) == 0;
            s.jump = $urandom_range(0, 3) == 0;
            s.br = $urandom_range(0, 3) == 0;
            s.call = $urandom_range(0, 1) == 1;
            s.ret = $urandom_range(0, 5) == 0;
            s.jt = $urandom;
            s.bt = $urandom;
            if ($urandom_range(0, 3) != 0) s.jt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) s.bt[1:0] = 2'b00;
            cyc(s);
        end
        cyc(idle());
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter controller for the MIPS core fetch stage.
- Successor to the single-register PC.
- Adds a boot cycle, stall hold, prioritised redirects (exception, jump, branch), target-alignment checking and a halt/resume state machine.
- Drives the instruction-memory address and the sequential-PC value used by the link/branch logic.

Parameters:
WIDTH, 32, PC width in bits
STEP, 4, sequential increment in bytes
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC value loaded on exception or misaligned target
ALIGN_BITS, 2, number of low target bits that must be zero; 0 disables the alignment check
RAS_DEPTH, 4, return-stack entries (used only with PC_RAS_EN)

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC (pipeline stall)
exc  input  1  exception redirect request
jump  input  1  unconditional jump request
jump_target  input  WIDTH  jump destination
branch_taken  input  1  resolved taken branch
branch_target  input  WIDTH  branch destination
halt  input  1  request halt
resume  input  1  leave HALT
call  input  1  jump is a call; push return address (PC_RAS_EN only)
ret  input  1  return; pop target (PC_RAS_EN only)
pc  output  WIDTH  current fetch address
pc_seq  output  WIDTH  pc + STEP, combinational
pc_valid  output  1  pc is a valid fetch address this cycle
misalign  output  1  one-cycle pulse: a redirect target failed the alignment check
ras_underflow  output  1  one-cycle pulse: ret issued while the stack was empty

Behaviour:
- Reset (reset=1 at a clock edge, any state, mid-operation included):
  - state=BOOT, pc=RESET_VECTOR, pc_valid=0, misalign=0, ras_underflow=0.
  - Return stack is emptied.
- BOOT: the next edge moves to RUN with pc=RESET_VECTOR unchanged and pc_valid=1. The first fetch is therefore at RESET_VECTOR. Inputs are ignored in BOOT.
- RUN, per-edge priority (highest first):
  1. exc: pc=EXC_VECTOR. Overrides stall and halt.
  2. stall: pc holds. halt is ignored while stalled.
  3. halt: move to HALT, pc holds, pc_valid=0 from the next cycle.
  4. ret (PC_RAS_EN): pc=popped entry.
  5. jump: pc=jump_target.
  6. branch_taken: pc=branch_target.
  7. Otherwise: pc=pc+STEP.
- Arithmetic is modulo 2^WIDTH. At pc = 2^WIDTH - STEP, the next sequential pc wraps to 0 with no flag.
- Alignment check applies to ret, jump and branch targets when ALIGN_BITS>0. A target whose low ALIGN_BITS are nonzero is not loaded; instead pc=EXC_VECTOR and misalign pulses high for exactly one cycle.
- HALT:
  - pc holds and pc_valid=0.
  - exc moves to RUN with pc=EXC_VECTOR and pc_valid=1.
  - Otherwise resume moves to RUN with pc unchanged and pc_valid=1.
  - exc and resume together: exc wins.
- pc_seq is always pc+STEP, including in BOOT and HALT.
- Simultaneous jump and branch_taken: jump wins.
- Outputs are registered except pc_seq.

Optional Feature:
PC_RAS_EN.
- Defined:
  - RAS_DEPTH-entry return-address stack.
  - jump&call, when the jump is accepted (not pre-empted by exc or stall), pushes the pre-jump pc+STEP.
  - A push while full overwrites the oldest entry (circular).
  - ret pops the top entry into pc.
  - ret while empty: pc=EXC_VECTOR and ras_underflow pulses for one cycle.
  - call with ret: ret is taken and no push occurs.
- Not defined: call and ret are ignored, ras_underflow is tied 0, and no stack storage is generated.

Test Plan:
- Reset then 3 idle cycles -> pc: 0x0 (pc_valid=0), 0x0 (valid=1), 0x4, 0x8.
- In RUN at pc=0x10: stall 2 cycles then jump=1, jump_target=0x40 -> pc 0x10, 0x10, then 0x40.
- branch_taken, branch_target=0x22 -> pc=0x80 and misalign pulses one cycle. The same test with exc and jump asserted together -> pc=0x80 and misalign stays 0.
- halt at pc=0x8 -> pc holds at 0x8 with pc_valid=0; resume -> pc_valid=1 and the next pc is 0xC. halt+exc together -> pc=0x80.
- Start at pc=0xFFFF_FFFC, idle one cycle -> pc=0x0 (wrap). Reset asserted during a stall -> pc=0x0 and state BOOT.
- PC_RAS_EN: call jump at pc=0x10 to 0x100, then ret -> pc=0x14. A second ret -> pc=0x80 and ras_underflow=1 for one cycle.
